freq_divider_prog: RTL

//   Programmable, run-time-reconfigurable frequency divider for the CLOCK_50 domain.

---
 rtl/freq_divider_prog.sv | 73 +++++++
 1 files changed

// File: rtl/freq_divider_prog.sv
// Programmable divider: square wave (toggle) or 1-clk strobe (pulse) output plus a
// terminal-count tick; divisor and mode are shadowed and take effect at period boundaries.
module freq_divider_prog #(
  parameter int   WIDTH    = 16,
  parameter logic INIT_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic [WIDTH-1:0] div_count,
  input  logic             pulse_mode,
  output logic             div_clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             mode_q, mode_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             term;

  assign term = (cnt_q == div_q);

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    mode_d = mode_q;
    out_d  = out_q;
    tick_d = 1'b0;
    if (restart) begin
      cnt_d  = '0;
      div_d  = div_count;
      mode_d = pulse_mode;
      out_d  = pulse_mode ? 1'b0 : INIT_OUT;
    end else if (enable) begin
      if (term) begin
        // Output follows the mode of the period that just ended; shadow loads the next one.
        cnt_d  = '0;
        tick_d = 1'b1;
        out_d  = mode_q ? 1'b1 : ~out_q;
        div_d  = div_count;
        mode_d = pulse_mode;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (mode_q) out_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= div_count;
      mode_q <= pulse_mode;
      out_q  <= pulse_mode ? 1'b0 : INIT_OUT;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      mode_q <= mode_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign div_clk_out = out_q;
  assign tick        = tick_q;
  assign count_out   = cnt_q;

endmodule
